// File: rtl/usbpd_tx_retry_ctl.sv
// USB PD protocol-layer transmit controller: launches one message on the PHY, waits for a matching GoodCRC, retries up to NRETRY times, and keeps per-SOP MessageID counters.
// Latency: an accepted tx_req gives tx_busy next cycle and phy_start the cycle after (line idle); each result pulse comes one cycle after the deciding rx_vld/timeout.
// Backpressure: tx_req is ignored while tx_busy; phy_start waits for cc_idle. USBPD_TXRETRY_SOPP_EN enables separate SOP'/SOP'' counters.
module usbpd_tx_retry_ctl #(
  parameter int TRCV_US = 1000,  // GoodCRC wait window in tick_us ticks (900..1100)
  parameter int NRETRY  = 2      // retries after the first attempt
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_us,
  input  logic        tx_req,
  input  logic [1:0]  tx_sop,
  output logic        tx_busy,
  output logic [2:0]  tx_msgid,
  output logic        phy_start,
  input  logic        phy_done,
  input  logic        cc_idle,
  input  logic        rx_vld,
  input  logic        rx_crc_ok,
  input  logic [1:0]  rx_sop,
  input  logic [15:0] rx_hdr,
  input  logic        msgid_clr,
  output logic        done_ok,
  output logic        done_fail,
  output logic        done_discard
);

  localparam int TW = $clog2(TRCV_US + 1);
  localparam int RW = (NRETRY > 0) ? $clog2(NRETRY + 1) : 1;
`ifdef USBPD_TXRETRY_SOPP_EN
  localparam int NSOP = 3;
`else
  localparam int NSOP = 1;
`endif

  typedef enum logic [2:0] {IDLE, WAIT_LINE, SEND, WAIT_CRC, FINISH} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sop_q, sop_nxt;
  logic [2:0]    id_q, id_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic [RW-1:0] retry_q, retry_nxt;
  logic          clr_seen_q, clr_seen_nxt;
  logic [2:0]    cnt_q [NSOP];
  logic          inc_en;
  logic          phy_start_nxt, ok_nxt, fail_nxt, disc_nxt;
  logic          sop_legal;
  logic [2:0]    req_id;
  logic          rx_hit, gcrc_type, gcrc_match, timeout;
  logic          unused_hdr;

  // Header bits that play no part in GoodCRC recognition.
  assign unused_hdr = ^{rx_hdr[15], rx_hdr[8:5]};

`ifdef USBPD_TXRETRY_SOPP_EN
  assign sop_legal = (tx_sop != 2'd3);
`else
  assign sop_legal = (tx_sop == 2'd0);
`endif

  // Counter value a new request on tx_sop would be sent with.
  always_comb begin
    req_id = cnt_q[0];
`ifdef USBPD_TXRETRY_SOPP_EN
    if (tx_sop == 2'd1)      req_id = cnt_q[1];
    else if (tx_sop == 2'd2) req_id = cnt_q[2];
`endif
  end

  assign tx_busy  = (state != IDLE);
  assign tx_msgid = (state == IDLE) ? req_id : id_q;

  // A packet on our SOP with good CRC. A GoodCRC-type header with the wrong
  // MessageID is stale and simply ignored; any other message pre-empts us.
  assign rx_hit     = rx_vld & rx_crc_ok & (rx_sop == sop_q);
  assign gcrc_type  = (rx_hdr[4:0] == 5'b00001) & (rx_hdr[14:12] == 3'd0);
  assign gcrc_match = rx_hit & gcrc_type & (rx_hdr[11:9] == id_q);
  assign timeout    = (timer_q == TW'(TRCV_US));

  // Next-state, datapath updates and registered result/launch pulses.
  always_comb begin
    state_nxt     = state;
    sop_nxt       = sop_q;
    id_nxt        = id_q;
    timer_nxt     = timer_q;
    retry_nxt     = retry_q;
    clr_seen_nxt  = clr_seen_q | msgid_clr;
    inc_en        = 1'b0;
    phy_start_nxt = 1'b0;
    ok_nxt        = 1'b0;
    fail_nxt      = 1'b0;
    disc_nxt      = 1'b0;
    case (state)
      IDLE: begin
        clr_seen_nxt = msgid_clr;
        if (tx_req) begin
          if (sop_legal) begin
            sop_nxt   = tx_sop;
            id_nxt    = req_id;
            retry_nxt = '0;
            state_nxt = WAIT_LINE;
          end else begin
            fail_nxt = 1'b1;
          end
        end
      end
      WAIT_LINE: begin
        if (cc_idle) begin
          phy_start_nxt = 1'b1;
          state_nxt     = SEND;
        end
      end
      SEND: begin
        // Receive activity here is our own transmission echoed back.
        if (phy_done) begin
          timer_nxt = '0;
          state_nxt = WAIT_CRC;
        end
      end
      WAIT_CRC: begin
        if (tick_us && !timeout) timer_nxt = timer_q + TW'(1);
        // A counter cleared during the transaction stays cleared: the next
        // message after a soft/hard reset must start from ID 0.
        if (gcrc_match) begin
          ok_nxt    = 1'b1;
          inc_en    = ~clr_seen_q;
          state_nxt = FINISH;
        end else if (rx_hit && !gcrc_type) begin
          disc_nxt  = 1'b1;
          state_nxt = FINISH;
        end else if (timeout) begin
          if (retry_q < RW'(NRETRY)) begin
            retry_nxt = retry_q + RW'(1);
            state_nxt = WAIT_LINE;
          end else begin
            fail_nxt  = 1'b1;
            inc_en    = ~clr_seen_q;
            state_nxt = FINISH;
          end
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, transaction context and output pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sop_q        <= 2'd0;
      id_q         <= 3'd0;
      timer_q      <= '0;
      retry_q      <= '0;
      clr_seen_q   <= 1'b0;
      phy_start    <= 1'b0;
      done_ok      <= 1'b0;
      done_fail    <= 1'b0;
      done_discard <= 1'b0;
    end else begin
      state        <= state_nxt;
      sop_q        <= sop_nxt;
      id_q         <= id_nxt;
      timer_q      <= timer_nxt;
      retry_q      <= retry_nxt;
      clr_seen_q   <= clr_seen_nxt;
      phy_start    <= phy_start_nxt;
      done_ok      <= ok_nxt;
      done_fail    <= fail_nxt;
      done_discard <= disc_nxt;
    end
  end

  // MessageID counters; a clear beats a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSOP; i++) cnt_q[i] <= 3'd0;
    end else begin
      for (int i = 0; i < NSOP; i++) begin
        if (msgid_clr)                       cnt_q[i] <= 3'd0;
        else if (inc_en && sop_q == 2'(i))   cnt_q[i] <= cnt_q[i] + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_usbpd_tx_retry_ctl.sv
// Directed bench for usbpd_tx_retry_ctl: success, retry exhaustion, stale GoodCRC, discard, ID wrap/clear, reset and illegal SOP.
// Latency: inputs driven and outputs sampled 1 ns after the rising edge; tick_us toggles on falling edges, one pulse per 4 cycles.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_usbpd_tx_retry_ctl;

  logic        clk, rst, tick_us, tx_req, phy_done, cc_idle;
  logic        rx_vld, rx_crc_ok, msgid_clr;
  logic [1:0]  tx_sop, rx_sop;
  logic [15:0] rx_hdr;
  logic        tx_busy, phy_start, done_ok, done_fail, done_discard;
  logic [2:0]  tx_msgid;

  int errors = 0;
  int checks = 0;
  int nstart = 0;

  usbpd_tx_retry_ctl #(.TRCV_US(1000), .NRETRY(2)) dut (
    .clk(clk), .rst(rst), .tick_us(tick_us), .tx_req(tx_req), .tx_sop(tx_sop),
    .tx_busy(tx_busy), .tx_msgid(tx_msgid), .phy_start(phy_start), .phy_done(phy_done),
    .cc_idle(cc_idle), .rx_vld(rx_vld), .rx_crc_ok(rx_crc_ok), .rx_sop(rx_sop),
    .rx_hdr(rx_hdr), .msgid_clr(msgid_clr), .done_ok(done_ok), .done_fail(done_fail),
    .done_discard(done_discard)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick_us = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick_us = 1'b1;
      @(negedge clk);
      tick_us = 1'b0;
    end
  end

  always @(negedge clk) if (phy_start === 1'b1) nstart++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [1:0] sop);
    tx_sop = sop; tx_req = 1'b1;
    step();
    tx_req = 1'b0;
  endtask

  task automatic pulse_phy_done();
    phy_done = 1'b1;
    step();
    phy_done = 1'b0;
  endtask

  task automatic send_rx(input logic [1:0] sop, input logic crc, input logic [15:0] hdr);
    rx_vld = 1'b1; rx_sop = sop; rx_crc_ok = crc; rx_hdr = hdr;
    step();
    rx_vld = 1'b0; rx_crc_ok = 1'b0;
  endtask

  function automatic logic [15:0] gcrc_hdr(input logic [2:0] id);
    return {4'b0000, id, 9'b0_0000_0001};
  endfunction

  // kind: 0 budget expired, 1 phy_start, 2 done_ok, 3 done_fail, 4 done_discard
  task automatic wait_event(input int max_cyc, output int ticks, output int kind);
    ticks = 0; kind = 0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (tick_us) ticks++;
      if (phy_start)    begin kind = 1; break; end
      if (done_ok)      begin kind = 2; break; end
      if (done_fail)    begin kind = 3; break; end
      if (done_discard) begin kind = 4; break; end
    end
  endtask

  task automatic wait_ticks(input int n);
    int t = 0;
    while (t < n) begin
      step();
      if (tick_us) t++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({tx_busy, tx_msgid, phy_start, done_ok, done_fail, done_discard} !== 8'h00) begin
      errors++; $display("FAIL reset_hold: outputs=%b want 00000000",
        {tx_busy, tx_msgid, phy_start, done_ok, done_fail, done_discard});
    end
    step(); rst = 1'b0; step();
    checks++;
    if ({tx_busy, tx_msgid, phy_start, done_ok, done_fail, done_discard} !== 8'h00) begin
      errors++; $display("FAIL reset_release: outputs=%b want 00000000",
        {tx_busy, tx_msgid, phy_start, done_ok, done_fail, done_discard});
    end
  endtask

  task automatic test_good_first();
    int t, k, s0;
    s0 = nstart;
    do_req(2'd0);
    checks++;
    if (tx_busy !== 1'b1 || phy_start !== 1'b0) begin
      errors++; $display("FAIL good_busy_n1: busy=%b start=%b want 1 0", tx_busy, phy_start);
    end
    step();
    checks++;
    if (phy_start !== 1'b1) begin
      errors++; $display("FAIL good_start_n2: start=%b want 1", phy_start);
    end
    repeat (3) step();
    pulse_phy_done();
    wait_ticks(300);
    send_rx(2'd0, 1'b1, gcrc_hdr(3'd0));
    checks++;
    if ({done_ok, done_fail, done_discard, tx_busy} !== 4'b1001 || tx_msgid !== 3'd0) begin
      errors++; $display("FAIL good_done: ok/fail/disc/busy=%b id=%0d want 1001 id 0",
        {done_ok, done_fail, done_discard, tx_busy}, tx_msgid);
    end
    step();
    checks++;
    if (tx_busy !== 1'b0 || done_ok !== 1'b0 || tx_msgid !== 3'd1 || nstart - s0 != 1) begin
      errors++; $display("FAIL good_after: busy=%b ok=%b id=%0d starts=%0d want 0 0 1 1",
        tx_busy, done_ok, tx_msgid, nstart - s0);
    end
  endtask

  task automatic test_retry_fail();
    int t, k, s0;
    s0 = nstart;
    do_req(2'd0);
    wait_event(50, t, k);
    checks++;
    if (k != 1) begin errors++; $display("FAIL retry_first_start: kind=%0d want 1", k); end
    for (int a = 0; a < 3; a++) begin
      pulse_phy_done();
      wait_event(5000, t, k);
      checks++;
      if (k != ((a < 2) ? 1 : 3) || t < 1000 || t > 1001) begin
        errors++; $display("FAIL retry_attempt%0d: kind=%0d ticks=%0d want kind %0d ticks 1000..1001",
          a, k, t, (a < 2) ? 1 : 3);
      end
    end
    step();
    checks++;
    if (tx_busy !== 1'b0 || tx_msgid !== 3'd2 || nstart - s0 != 3) begin
      errors++; $display("FAIL retry_after: busy=%b id=%0d starts=%0d want 0 2 3",
        tx_busy, tx_msgid, nstart - s0);
    end
  endtask

  task automatic test_wrong_id_retry();
    int t, k, s0;
    s0 = nstart;
    do_req(2'd0);
    wait_event(50, t, k);
    pulse_phy_done();
    send_rx(2'd0, 1'b1, gcrc_hdr(3'd5));
    checks++;
    if ({done_ok, done_fail, done_discard} !== 3'b000 || tx_busy !== 1'b1) begin
      errors++; $display("FAIL wrongid_ignored: done=%b busy=%b want 000 1",
        {done_ok, done_fail, done_discard}, tx_busy);
    end
    wait_event(5000, t, k);
    checks++;
    if (k != 1) begin errors++; $display("FAIL wrongid_retry: kind=%0d want 1", k); end
    pulse_phy_done();
    wait_ticks(10);
    send_rx(2'd0, 1'b1, gcrc_hdr(3'd2));
    checks++;
    if (done_ok !== 1'b1 || nstart - s0 != 2) begin
      errors++; $display("FAIL wrongid_ok: ok=%b starts=%0d want 1 2", done_ok, nstart - s0);
    end
    step();
    checks++;
    if (tx_msgid !== 3'd3) begin errors++; $display("FAIL wrongid_id: id=%0d want 3", tx_msgid); end
  endtask

  task automatic test_discard();
    int t, k, s0;
    s0 = nstart;
    cc_idle = 1'b0;
    do_req(2'd0);
    repeat (5) step();
    checks++;
    if (nstart != s0 || tx_busy !== 1'b1) begin
      errors++; $display("FAIL disc_line_busy: starts=%0d busy=%b want 0 1", nstart - s0, tx_busy);
    end
    cc_idle = 1'b1;
    wait_event(50, t, k);
    send_rx(2'd0, 1'b1, gcrc_hdr(3'd3));   // own echo while sending
    pulse_phy_done();
    send_rx(2'd0, 1'b0, gcrc_hdr(3'd3));   // bad CRC
    tx_req = 1'b1; step(); tx_req = 1'b0;  // request while busy
    send_rx(2'd1, 1'b1, 16'h1043);         // other SOP
    checks++;
    if ({done_ok, done_fail, done_discard} !== 3'b000 || tx_busy !== 1'b1) begin
      errors++; $display("FAIL disc_ignored: done=%b busy=%b want 000 1",
        {done_ok, done_fail, done_discard}, tx_busy);
    end
    send_rx(2'd0, 1'b1, 16'h1043);
    checks++;
    if ({done_ok, done_fail, done_discard} !== 3'b001) begin
      errors++; $display("FAIL disc_pulse: ok/fail/disc=%b want 001", {done_ok, done_fail, done_discard});
    end
    step();
    checks++;
    if (tx_busy !== 1'b0 || tx_msgid !== 3'd3 || nstart - s0 != 1) begin
      errors++; $display("FAIL disc_after: busy=%b id=%0d starts=%0d want 0 3 1",
        tx_busy, tx_msgid, nstart - s0);
    end
  endtask

  task automatic run_ok(input logic [2:0] id);
    int t, k;
    do_req(2'd0);
    wait_event(50, t, k);
    pulse_phy_done();
    send_rx(2'd0, 1'b1, gcrc_hdr(id));
    checks++;
    if (done_ok !== 1'b1) begin errors++; $display("FAIL run_ok_id%0d: ok=%b want 1", id, done_ok); end
    step();
  endtask

  task automatic test_wrap_and_clr();
    int t, k;
    for (int i = 3; i < 8; i++) run_ok(3'(i));
    checks++;
    if (tx_msgid !== 3'd0) begin errors++; $display("FAIL wrap: id=%0d want 0", tx_msgid); end
    run_ok(3'd0);
    run_ok(3'd1);
    do_req(2'd0);
    wait_event(50, t, k);
    pulse_phy_done();
    msgid_clr = 1'b1; step(); msgid_clr = 1'b0;
    checks++;
    if (tx_msgid !== 3'd2) begin errors++; $display("FAIL clr_latched: id=%0d want 2", tx_msgid); end
    send_rx(2'd0, 1'b1, gcrc_hdr(3'd2));
    checks++;
    if (done_ok !== 1'b1) begin errors++; $display("FAIL clr_match: ok=%b want 1", done_ok); end
    step();
    checks++;
    if (tx_msgid !== 3'd0) begin errors++; $display("FAIL clr_after: id=%0d want 0", tx_msgid); end
  endtask

  task automatic test_bad_sop();
    int s0;
    s0 = nstart;
    do_req(2'd3);
    checks++;
    if (done_fail !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL sop3_reject: fail=%b busy=%b want 1 0", done_fail, tx_busy);
    end
`ifndef USBPD_TXRETRY_SOPP_EN
    step();
    do_req(2'd1);
    checks++;
    if (done_fail !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL sop1_reject: fail=%b busy=%b want 1 0", done_fail, tx_busy);
    end
`endif
    tx_sop = 2'd0;
    repeat (5) step();
    checks++;
    if (nstart != s0 || done_fail !== 1'b0) begin
      errors++; $display("FAIL badsop_nostart: starts=%0d fail=%b want 0 0", nstart - s0, done_fail);
    end
  endtask

  task automatic test_reset_mid();
    int t, k, s0;
    run_ok(3'd0);
    do_req(2'd0);
    wait_event(50, t, k);
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_busy, tx_msgid, phy_start, done_ok, done_fail, done_discard} !== 8'h00) begin
      errors++; $display("FAIL rst_mid: outputs=%b want 00000000",
        {tx_busy, tx_msgid, phy_start, done_ok, done_fail, done_discard});
    end
    step(); rst = 1'b0;
    s0 = nstart;
    pulse_phy_done();
    send_rx(2'd0, 1'b1, gcrc_hdr(3'd1));
    repeat (3) step();
    checks++;
    if ({tx_busy, done_ok, done_fail, done_discard} !== 4'b0000 || nstart != s0) begin
      errors++; $display("FAIL rst_quiet: busy/ok/fail/disc=%b starts=%0d want 0000 0",
        {tx_busy, done_ok, done_fail, done_discard}, nstart - s0);
    end
  endtask

  initial begin
    rst = 1'b1; tx_req = 1'b0; tx_sop = 2'd0; phy_done = 1'b0; cc_idle = 1'b1;
    rx_vld = 1'b0; rx_crc_ok = 1'b0; rx_sop = 2'd0; rx_hdr = 16'h0000; msgid_clr = 1'b0;
    #2;
    test_reset();
    test_good_first();
    test_retry_fail();
    test_wrong_id_retry();
    test_discard();
    test_wrap_and_clr();
    test_bad_sop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usbpd_tx_retry_ctl.md
# usbpd_tx_retry_ctl

USB PD protocol-layer transmit controller between the policy engine and the BMC PHY transmitter. Accepts one message-send request, launches it on the PHY, waits tReceive for a matching GoodCRC from the receive path, retries up to NRETRY times, and maintains per-SOP MessageID counters. Reports success, failure after retries, or discard when an incoming message pre-empts the transaction.

## Interface
- TRCV_US, 1000: GoodCRC wait window in `tick_us` ticks; must lie within 900–1100.
- NRETRY, 2: retries after the first attempt; total attempts = NRETRY+1.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick_us  in  1  one-cycle pulse every 1 µs
- tx_req  in  1  start a transaction; sampled only in IDLE
- tx_sop  in  2  ordered set: 0=SOP, 1=SOP', 2=SOP''; 3 illegal
- tx_busy  out  1  high from accepted request until the cycle after a done pulse
- tx_msgid  out  3  MessageID of the current/next transaction for the header builder
- phy_start  out  1  one-cycle launch pulse to PHY transmitter
- phy_done  in  1  one-cycle pulse: PHY finished sending EOP
- cc_idle  in  1  line idle (no BMC activity)
- rx_vld  in  1  one-cycle pulse: received packet complete
- rx_crc_ok  in  1  CRC32 of received packet valid; qualified by rx_vld
- rx_sop  in  2  ordered set of received packet
- rx_hdr  in  16  received message header
- msgid_clr  in  1  clear all MessageID counters (soft/hard reset)
- done_ok, done_fail, done_discard  out  1 each  one-cycle result pulses, mutually exclusive

## Operation
- States: IDLE, WAIT_LINE, SEND, WAIT_CRC, FINISH.
- IDLE: tx_req=1 and tx_sop legal → latch tx_sop, retry count = 0, go WAIT_LINE. tx_sop=3 → done_fail next cycle, stay IDLE.
- WAIT_LINE: cc_idle=1 → phy_start pulse, go SEND.
- SEND: phy_done → clear timer, go WAIT_CRC. rx_vld here ignored (own echo).
- WAIT_CRC: timer increments on tick_us.
  - GoodCRC match = rx_vld & rx_crc_ok & rx_sop==latched sop & rx_hdr[4:0]==5'b00001 & rx_hdr[14:12]==0 & rx_hdr[11:9]==tx_msgid → done_ok, increment that SOP's counter, go FINISH.
  - rx_vld & rx_crc_ok & rx_sop==latched sop, not GoodCRC → done_discard, counter unchanged, FINISH.
  - rx_vld with bad CRC or other SOP → ignored.
  - timer==TRCV_US: retry count<NRETRY → increment retry, WAIT_LINE; else done_fail, increment counter, FINISH.
- FINISH: one cycle, tx_busy falls, back to IDLE.
- MessageID counters: 3 bits each, wrap 7→0. msgid_clr zeros all next cycle; mid-transaction the latched ID is kept, clear applies to the counter only; a coincident increment loses to clear.
- tx_msgid = counter of tx_sop in IDLE, of latched SOP otherwise.
- tx_req while tx_busy ignored.

## Timing
- Reset values: state IDLE, all counters 0, tx_busy 0, tx_msgid 0, phy_start 0, all done pulses 0.
- tx_req at cycle N with cc_idle=1 → tx_busy=1 at N+1, phy_start at N+2.
- Result pulse one cycle after the deciding rx_vld/timeout; tx_busy low one cycle after pulse.
- GoodCRC and timeout in same cycle: GoodCRC wins.
- Timer width clog2(TRCV_US+1), saturates; retry count width clog2(NRETRY+1).
- Reset mid-transaction: immediate return to IDLE, phy_start deasserted, no result pulse.

## Configuration
- USBPD_TXRETRY_SOPP_EN defined: three independent MessageID counters (SOP, SOP', SOP'').
- Not defined: single SOP counter only; tx_sop≠0 rejected in IDLE with done_fail; rx_sop≠0 packets ignored in WAIT_CRC.

## Test plan
- SOP request, GoodCRC with ID 0 at 300 µs after phy_done → done_ok, one phy_start, tx_msgid becomes 1.
- No GoodCRC, NRETRY=2 → phy_start 3 times spaced 1000 µs after each phy_done, done_fail, ID increments.
- GoodCRC with wrong MessageID, then correct one on retry → done_ok after 2 attempts.
- Valid non-GoodCRC SOP packet during WAIT_CRC → done_discard, ID unchanged.
- ID 7 success → wraps to 0; msgid_clr during WAIT_CRC → current ID still matched, counter 0 afterward.
- rst asserted in SEND → all outputs 0 immediately; with macro off, tx_sop=1 → done_fail, no phy_start.
